uart_rx_sample_ctrl: RTL and testbench
======================================

Name: uart_rx_sample_ctrl

Overview:
- Receive-side sequencer for the UART oversampled timing path.
- Consumes the oversampling tick from the baud rate generator, detects the start bit, and centres sampling at mid-bit.
- Shifts in data, optional parity and stop bit, then presents the byte with error flags on a valid/ready handshake to the receive buffer.
- Also tells the baud generator's sampling counter when a frame is in progress.

Parameters:
- OVERSAMPLING, 8, os_tick pulses per bit period. Must be even and >= 4.
- DATA_BITS, 8, data bits per frame. Legal range 5..9.

Ports:
- base_clock  input  1  system clock for all logic.
- nreset  input  1  asynchronous, active-low reset.
- os_tick  input  1  one-cycle pulse at BAUDRATE*OVERSAMPLING, synchronous to base_clock.
- rx  input  1  raw serial line, asynchronous, idle high.
- cfg_parity_en  input  1  1 = parity bit present after data.
- cfg_parity_odd  input  1  1 = odd parity, 0 = even.
- sample_ena  output  1  high while a frame is in progress; drives the generator's sampling-counter enable.
- rx_data  output  DATA_BITS  received word, LSB first on the line.
- rx_valid  output  1  rx_data and the error flags are valid.
- rx_ready  input  1  consumer accepts the word.
- frame_err  output  1  stop bit sampled 0; qualified by rx_valid.
- parity_err  output  1  parity mismatch; qualified by rx_valid; 0 when parity disabled.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- Reset: state IDLE, counters 0, synchroniser flops 1. All outputs 0, except rx_data = 0.
- rx passes through a 2-flop synchroniser (rx_s). Edge detection uses rx_s and a delayed copy rx_d.
- Latency: rx_s lags rx by 2 cycles.
- cfg_parity_en and cfg_parity_odd are latched on start detection. Changes mid-frame have no effect.
- os_cnt has width $clog2(OVERSAMPLING) and increments only on os_tick.
- bit_cnt counts data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A falling edge (rx_d=1, rx_s=0) moves to START with os_cnt=0.
  - os_tick is ignored in IDLE.
- START:
  - On the os_tick where os_cnt == OVERSAMPLING/2-1, sample rx_s.
  - rx_s = 0: go to DATA, os_cnt=0, bit_cnt=0.
  - rx_s = 1: false start, go to IDLE with no output.
- DATA:
  - On the os_tick where os_cnt == OVERSAMPLING-1, sample rx_s into the shift register MSB side (right shift), os_cnt wraps to 0, bit_cnt+1.
  - After DATA_BITS samples, go to PARITY if latched parity_en, else STOP.
- PARITY: same sampling rule. Store computed mismatch: (^data ^ sampled_bit) != odd. Then go to STOP.
- STOP:
  - Same sampling rule. frame_err_next = ~rx_s. Go to IDLE on the same cycle.
  - Returning at mid-stop lets the next start edge be caught. After a break (line held low), a new start needs rx_s to return high first.
- sample_ena = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Completion (stop-bit sample cycle), registered one cycle later:
  - If rx_valid=0, or rx_valid&rx_ready on that cycle: load rx_data, frame_err, parity_err; rx_valid=1.
  - Otherwise the new frame is dropped, the old word is kept, and overrun pulses 1 cycle.
- Handshake:
  - rx_valid holds until rx_valid&rx_ready, then clears the next cycle unless a completion loads simultaneously.
  - rx_data and the flags are stable while rx_valid=1 and not accepted.
- os_tick on consecutive cycles is legal.
- nreset asserted mid-frame aborts immediately to reset values. The partial frame is never delivered.

Test Plan:
- OVERSAMPLING=8, DATA_BITS=8, os_tick every 4 clocks, parity off, rx_ready=1. Send 0xA5, stop=1 -> one rx_valid pulse, rx_data=0xA5, frame_err=0, parity_err=0; sample_ena high from start detect to mid-stop.
- Parity on, even: send 0x03 with parity bit 0 -> parity_err=0. Repeat with parity bit 1 -> parity_err=1. Odd mode with 0x07 and parity 0 -> parity_err=0.
- Glitch: rx low for 2 os_ticks then high -> FSM returns to IDLE, no rx_valid, sample_ena low again within 1 cycle after the mid-start sample.
- Stop bit 0 on 0x5A -> rx_valid=1 with frame_err=1. Line held low 20 bit times then a valid 0x11 frame -> second word delivered only after rx returns high.
- rx_ready=0, two back-to-back frames 0x11, 0x22 -> rx_data stays 0x11, overrun pulses once at second completion. Then rx_ready=1 -> accepted, rx_valid clears. Also: frame completes on the same cycle as acceptance -> new word loads, rx_valid stays 1, no overrun.
- nreset pulsed during data bit 4 of 0xFF -> all outputs 0, FSM in IDLE. Next full frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_sample_ctrl_if.sv
// Receive-word handshake between the UART receive sequencer and the receive buffer.
// The sequencer drives the word and its error flags; the buffer answers with rx_ready.
`timescale 1ns/1ps
interface uart_rx_sample_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sample_ctrl.sv
// UART receive sequencer: synchronises rx, finds the start bit, samples each bit at its
// centre using the oversampling tick, and hands the word plus error flags to the buffer.
`timescale 1ns/1ps
module uart_rx_sample_ctrl #(
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic base_clock,
  input  logic nreset,
  input  logic os_tick,
  input  logic rx,
  input  logic cfg_parity_en,
  input  logic cfg_parity_odd,
  output logic sample_ena,
  output logic overrun,
  uart_rx_sample_ctrl_if.master out_if
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e               state_q;
  logic [CW-1:0]        os_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_en_q;
  logic                 par_odd_q;
  logic                 par_err_q;
  logic                 sample_ena_q;

  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic                 rx_d_q;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_q;

  logic                 start_edge;
  logic                 cnt_hit;
  logic                 sample_now;
  logic                 stop_sample;
  logic                 parity_mismatch_d;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle-high line.
  always_ff @(posedge base_clock or negedge nreset) begin
    if (!nreset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  // Sampling strobes: START samples at half a bit, later states at a full bit period.
  always_comb begin
    start_edge        = rx_d_q & ~rx_s_q;
    cnt_hit           = (state_q == START) ? (os_cnt_q == HALF_M1) : (os_cnt_q == FULL_M1);
    sample_now        = os_tick && cnt_hit && (state_q != IDLE);
    stop_sample       = sample_now && (state_q == STOP);
    parity_mismatch_d = ((^shift_q) ^ rx_s_q) != par_odd_q;
  end

  // Frame sequencer; os_cnt always wraps to 0 on a sample, so it is already 0 in IDLE.
  always_ff @(posedge base_clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_err_q    <= 1'b0;
      sample_ena_q <= 1'b0;
    end else begin
      if (state_q != IDLE && os_tick) begin
        os_cnt_q <= cnt_hit ? '0 : os_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q      <= START;
            os_cnt_q     <= '0;
            sample_ena_q <= 1'b1;
            par_en_q     <= cfg_parity_en;
            par_odd_q    <= cfg_parity_odd;
            par_err_q    <= 1'b0;
          end
        end
        START: begin
          if (sample_now) begin
            if (!rx_s_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              state_q      <= IDLE;
              sample_ena_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (sample_now) begin
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample_now) begin
            par_err_q <= parity_mismatch_d;
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (sample_now) begin
            state_q      <= IDLE;
            sample_ena_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          sample_ena_q <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: load on the stop sample if the slot is free or being freed, else flag overrun.
  always_ff @(posedge base_clock or negedge nreset) begin
    if (!nreset) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (stop_sample) begin
        if (!rx_valid_q || out_if.rx_ready) begin
          rx_data_q    <= shift_q;
          frame_err_q  <= ~rx_s_q;
          parity_err_q <= par_en_q & par_err_q;
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && out_if.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign sample_ena        = sample_ena_q;
  assign overrun           = overrun_q;
  assign out_if.rx_data    = rx_data_q;
  assign out_if.rx_valid   = rx_valid_q;
  assign out_if.frame_err  = frame_err_q;
  assign out_if.parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_sample_ctrl.sv
// Bench for uart_rx_sample_ctrl: serial frames are driven bit by bit, expected words are
// queued as frames are sent, and a monitor pops and compares them on each accepted word.
`timescale 1ns/1ps
module tb_uart_rx_sample_ctrl;

  localparam int BIT_CLKS = 32;  // 8 ticks per bit, one tick every 4 clocks

  logic base_clock = 1'b0;
  logic nreset = 1'b0;
  logic os_tick = 1'b0;
  logic rx = 1'b1;
  logic cfg_parity_en = 1'b0;
  logic cfg_parity_odd = 1'b0;
  logic sample_ena;
  logic overrun;

  uart_rx_sample_ctrl_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_sample_ctrl #(.OVERSAMPLING(8), .DATA_BITS(8)) dut (
    .base_clock     (base_clock),
    .nreset         (nreset),
    .os_tick        (os_tick),
    .rx             (rx),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .sample_ena     (sample_ena),
    .overrun        (overrun),
    .out_if         (rx_if)
  );

  always #5 base_clock = ~base_clock;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pushed = 0;
  int   n_deliv = 0;
  int   n_overrun = 0;
  int   tick_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Oversampling tick: updated between edges, high for one clock in every four.
  initial begin
    forever begin
      @(posedge base_clock);
      #2;
      tick_cnt = (tick_cnt + 1) % 4;
      os_tick  = (tick_cnt == 0);
    end
  end

  // Monitor: scoreboard pop on every accepted word, overrun pulse counting.
  initial begin
    exp_t e;
    forever begin
      @(negedge base_clock);
      #1;
      if (overrun === 1'b1) n_overrun++;
      if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) begin
        check("word_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("RX word 0x%02h frame_err %0d parity_err %0d (expected 0x%02h %0d %0d)",
                   rx_if.rx_data, rx_if.frame_err, rx_if.parity_err, e.d, e.fe, e.pe);
          check("rx_data", rx_if.rx_data, e.d);
          check("frame_err", rx_if.frame_err, e.fe);
          check("parity_err", rx_if.parity_err, e.pe);
          n_deliv++;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait for a negedge at which the next posedge carries an os_tick, for repeatable timing.
  task automatic align();
    do @(negedge base_clock); while (tick_cnt != 0);
  endtask

  task automatic hold(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge base_clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input logic stop_bit);
    hold(1'b0, BIT_CLKS / 2);
    check("sample_ena_in_start", sample_ena, 1);
    hold(1'b0, BIT_CLKS / 2);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
    if (par_en) hold(par_bit, BIT_CLKS);
    hold(stop_bit, BIT_CLKS);
    check("sample_ena_after_stop", sample_ena, 0);
  endtask

  task automatic run_parity(input logic [7:0] d, input logic odd, input logic pbit,
                            input logic exp_pe);
    cfg_parity_en  = 1'b1;
    cfg_parity_odd = odd;
    push_exp(d, 1'b0, exp_pe);
    align();
    send_frame(d, 1'b1, pbit, 1'b1);
    hold(1'b1, BIT_CLKS);
  endtask

  initial begin
    int lat;
    int found;
    int d0;
    int ov0;
    lat   = 0;
    found = 0;
    rx_if.rx_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge base_clock);
    #1;
    check("rst_rx_valid", rx_if.rx_valid, 0);
    check("rst_rx_data", rx_if.rx_data, 0);
    check("rst_sample_ena", sample_ena, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", rx_if.frame_err, 0);
    check("rst_parity_err", rx_if.parity_err, 0);
    @(negedge base_clock);
    nreset = 1'b1;
    hold(1'b1, BIT_CLKS);

    // Plain 8N1 frame
    push_exp(8'hA5, 1'b0, 1'b0);
    align();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    hold(1'b1, BIT_CLKS);

    // Parity: even correct, even wrong, odd correct
    run_parity(8'h03, 1'b0, 1'b0, 1'b0);
    run_parity(8'h03, 1'b0, 1'b1, 1'b1);
    run_parity(8'h07, 1'b1, 1'b0, 1'b0);
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;

    // Glitch: low for two ticks only
    align();
    rx = 1'b0;
    repeat (6) @(negedge base_clock);
    check("glitch_sample_ena_on", sample_ena, 1);
    repeat (2) @(negedge base_clock);
    rx = 1'b1;
    repeat (9) @(negedge base_clock);
    check("glitch_sample_ena_off", sample_ena, 0);
    check("glitch_no_valid", rx_if.rx_valid, 0);
    hold(1'b1, BIT_CLKS);

    // Stop bit 0, then line held low (break), then a clean frame
    d0 = n_deliv;
    push_exp(8'h5A, 1'b1, 1'b0);
    align();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 19 * BIT_CLKS);
    check("break_sample_ena", sample_ena, 0);
    check("break_deliveries", n_deliv - d0, 1);
    hold(1'b1, 2 * BIT_CLKS);
    push_exp(8'h11, 1'b0, 1'b0);
    align();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("after_break_deliveries", n_deliv - d0, 2);

    // Overrun: consumer stalled, two back-to-back frames
    rx_if.rx_ready = 1'b0;
    ov0 = n_overrun;
    push_exp(8'h11, 1'b0, 1'b0);
    align();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    hold(1'b1, BIT_CLKS);
    check("ovr_valid_held", rx_if.rx_valid, 1);
    check("ovr_data_kept", rx_if.rx_data, 8'h11);
    check("ovr_pulses", n_overrun - ov0, 1);
    rx_if.rx_ready = 1'b1;
    repeat (2) @(negedge base_clock);
    check("ovr_valid_cleared", rx_if.rx_valid, 0);

    // Measure start-to-valid latency of an aligned frame
    push_exp(8'h44, 1'b0, 1'b0);
    align();
    fork
      send_frame(8'h44, 1'b0, 1'b0, 1'b1);
      begin
        for (int k = 1; k <= 4000 && found == 0; k++) begin
          @(negedge base_clock);
          #1;
          if (rx_if.rx_valid === 1'b1) begin
            found = 1;
            lat   = k;
          end
        end
      end
    join
    check("latency_found", found, 1);
    hold(1'b1, BIT_CLKS);

    // Completion on the same cycle as acceptance of the held word
    rx_if.rx_ready = 1'b0;
    push_exp(8'h33, 1'b0, 1'b0);
    align();
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    hold(1'b1, BIT_CLKS);
    ov0 = n_overrun;
    push_exp(8'h44, 1'b0, 1'b0);
    align();
    fork
      send_frame(8'h44, 1'b0, 1'b0, 1'b1);
      begin
        if (found != 0) begin
          repeat (lat - 1) @(negedge base_clock);
          rx_if.rx_ready = 1'b1;
          @(negedge base_clock);
          rx_if.rx_ready = 1'b0;
        end
      end
    join
    hold(1'b1, BIT_CLKS);
    check("same_cycle_valid", rx_if.rx_valid, 1);
    check("same_cycle_data", rx_if.rx_data, 8'h44);
    check("same_cycle_no_overrun", n_overrun - ov0, 0);
    rx_if.rx_ready = 1'b1;
    repeat (2) @(negedge base_clock);
    check("same_cycle_cleared", rx_if.rx_valid, 0);

    // Asynchronous reset during data bit 4 of 0xFF
    align();
    fork
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      begin
        repeat (176) @(negedge base_clock);
        check("pre_reset_sample_ena", sample_ena, 1);
        nreset = 1'b0;
        #1;
        check("midrst_sample_ena", sample_ena, 0);
        check("midrst_rx_valid", rx_if.rx_valid, 0);
        check("midrst_rx_data", rx_if.rx_data, 0);
        check("midrst_flags", {rx_if.frame_err, rx_if.parity_err, overrun}, 0);
        @(negedge base_clock);
        nreset = 1'b1;
      end
    join
    hold(1'b1, BIT_CLKS);
    push_exp(8'h3C, 1'b0, 1'b0);
    align();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 2 * BIT_CLKS);

    check("queue_empty", exp_q.size(), 0);
    check("deliveries", n_deliv, n_pushed);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
